// File: rtl/rr_gate_pkg.sv
// Shared types and defaults for the round-robin gate arbiter.
// Opcode encoding, output-stage states and the id-width helper live here.
package rr_gate_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;

  typedef enum logic [1:0] {
    OP_AND   = 2'b00,
    OP_OR    = 2'b01,
    OP_XOR   = 2'b10,
    OP_NOT_A = 2'b11
  } gate_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_gate_arbiter_if.sv
// Request/response bundle between N_REQ requesters, the arbiter and the consumer.
// The arbiter uses the slave view; the requester/consumer side uses master.
interface rr_gate_arbiter_if
  import rr_gate_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0][W-1:0]  req_a;
  logic [N_REQ-1:0][W-1:0]  req_b;
  logic [N_REQ-1:0][1:0]    req_op;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [W-1:0]             rsp_data;
  logic [ID_W-1:0]          rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/mux2.sv
// One-bit 2:1 multiplexer; the only logic primitive the gate unit is built from.
module mux2 (
  input  logic sel_i,
  input  logic d0_i,
  input  logic d1_i,
  output logic y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_gate_unit.sv
// Shared W-bit gate unit (AND/OR/XOR/NOT a) made purely of mux2 instances and 0/1 constants.
// Each gate uses operand a as the mux select; the opcode then picks one of the four.
module mux_gate_unit
  import rr_gate_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  gate_op_t     op,
  output logic [W-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic and_w, or_w, nb_w, xor_w, na_w, lo_w, hi_w;

      mux2 u_and  (.sel_i(a[gi]),  .d0_i(1'b0),    .d1_i(b[gi]),  .y_o(and_w));
      mux2 u_or   (.sel_i(a[gi]),  .d0_i(b[gi]),   .d1_i(1'b1),   .y_o(or_w));
      mux2 u_nb   (.sel_i(b[gi]),  .d0_i(1'b1),    .d1_i(1'b0),   .y_o(nb_w));
      mux2 u_xor  (.sel_i(a[gi]),  .d0_i(b[gi]),   .d1_i(nb_w),   .y_o(xor_w));
      mux2 u_na   (.sel_i(a[gi]),  .d0_i(1'b1),    .d1_i(1'b0),   .y_o(na_w));
      // op[0] picks within {AND,OR} and {XOR,NOT}; op[1] picks the pair.
      mux2 u_lo   (.sel_i(op[0]),  .d0_i(and_w),   .d1_i(or_w),   .y_o(lo_w));
      mux2 u_hi   (.sel_i(op[0]),  .d0_i(xor_w),   .d1_i(na_w),   .y_o(hi_w));
      mux2 u_sel  (.sel_i(op[1]),  .d0_i(lo_w),    .d1_i(hi_w),   .y_o(y[gi]));
    end
  endgenerate

endmodule

// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter feeding a shared mux-based gate unit into a one-entry output register.
// A grant is only issued when the output register is empty or draining this cycle.
module rr_gate_arbiter
  import rr_gate_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  rr_gate_arbiter_if.slave bus
);

  localparam int ID_W = id_width(N_REQ);

  out_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [W-1:0]     data_q, data_d;

  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  logic             can_accept;
  logic             xfer;
  logic [N_REQ-1:0] ready;
  logic [W-1:0]     gate_y;
  int               scan_idx;

  // Scan offsets from highest to lowest so the offset closest to ptr is written last.
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    scan_idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (bus.req_valid[scan_idx]) begin
        win_idx   = ID_W'(scan_idx);
        win_found = 1'b1;
      end
    end
  end

  assign can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;

  always_comb begin
    ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ready[i] = !rst && can_accept && win_found && (win_idx == ID_W'(i));
    end
  end

  assign xfer = |ready;

  mux_gate_unit #(.W(W)) u_gate (
    .a  (bus.req_a[win_idx]),
    .b  (bus.req_b[win_idx]),
    .op (gate_op_t'(bus.req_op[win_idx])),
    .y  (gate_y)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d = gate_y;
      id_d   = win_idx;
      ptr_d  = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// Self-checking bench for rr_gate_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of arbitration and the output register.
module tb_rr_gate_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rr_gate_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  rr_gate_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_gate(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i]  = '0;
      bus.req_b[i]  = '0;
      bus.req_op[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h id=%0d expected 0/00/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_a[2] = 8'hF0;
    bus.req_b[2] = 8'h3C;
    bus.req_op[2] = 2'b10;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hCC || bus.rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_rsp: got valid=%b data=%h id=%0d expected 1/cc/2",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_ready_after: got %b expected 0000", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i]  = 8'h11 * (i + 1);
      bus.req_b[i]  = 8'h5A;
      bus.req_op[i] = 2'(i);
    end
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic [3:0] exp_rdy;
      int prev;
      exp_rdy = 4'(1 << (c % N));
      prev = (c + N - 1) % N;
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.req_ready, exp_rdy);
      end
      if (c > 0) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(prev) ||
            bus.rsp_data !== ref_gate(bus.req_a[prev], bus.req_b[prev], bus.req_op[prev])) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d data=%h expected 1/%0d/%h", c,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, prev,
                   ref_gate(bus.req_a[prev], bus.req_b[prev], bus.req_op[prev]));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_a[1] = 8'h3C;
    bus.req_b[1] = 8'h0F;
    bus.req_op[1] = 2'b01;
    bus.req_a[2] = 8'hFF;
    bus.req_b[2] = 8'h81;
    bus.req_op[2] = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    held = 8'h3F;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 ||
          bus.rsp_id !== 2'd1 || bus.rsp_data !== held) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b id=%0d data=%h expected 0000/1/1/%h",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, held);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_grant: got %b expected 0100", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 8'h81) begin
      errors++;
      $display("FAIL bp_next_rsp: got valid=%b id=%0d data=%h expected 1/2/81",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_opcodes();
    logic [W-1:0] exp_tab [4];
    exp_tab[0] = 8'h05;
    exp_tab[1] = 8'hAF;
    exp_tab[2] = 8'hAA;
    exp_tab[3] = 8'h5A;
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_a[0] = 8'hA5;
    bus.req_b[0] = 8'h0F;
    bus.rsp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      bus.req_op[0] = 2'(op);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_tab[op]) begin
        errors++;
        $display("FAIL opcode[%0d]: got valid=%b data=%h expected 1/%h",
                 op, bus.rsp_valid, bus.rsp_data, exp_tab[op]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant: got %b expected 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.rsp_id !== 2'd1 || bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_ptr: got id=%0d ready=%b expected 1/0100", bus.rsp_id, bus.req_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_a[2] = 8'h77;
    bus.req_op[2] = 2'b11;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got ready=%b valid=%b expected 0000/1",
               bus.req_ready, bus.rsp_valid);
    end
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_out: got valid=%b data=%h id=%0d expected 0/00/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: got ready=%b expected 0001", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    bit [N-1:0] pend;
    int m_ptr, win;
    bit m_full;
    logic [W-1:0] m_data;
    logic [1:0] m_id;
    logic [N-1:0] exp_rdy;
    do_reset();
    pend = '0;
    m_ptr = 0;
    m_full = 1'b0;
    m_data = '0;
    m_id = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          bus.req_a[i]  = W'($urandom);
          bus.req_b[i]  = W'($urandom);
          bus.req_op[i] = 2'($urandom_range(0, 3));
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = -1;
      for (int k = N - 1; k >= 0; k--) begin
        if (pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if (!rst && win >= 0 && (!m_full || bus.rsp_ready)) exp_rdy[win] = 1'b1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, bus.req_ready, exp_rdy);
      end
      checks++;
      if (bus.rsp_valid !== m_full || (m_full && (bus.rsp_data !== m_data || bus.rsp_id !== m_id))) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got valid=%b data=%h id=%0d expected %b/%h/%0d", cyc,
                 bus.rsp_valid, bus.rsp_data, bus.rsp_id, m_full, m_data, m_id);
      end
      if (rst) begin
        m_full = 1'b0;
        m_ptr  = 0;
        m_data = '0;
        m_id   = '0;
      end else if (exp_rdy != '0) begin
        m_full = 1'b1;
        m_data = ref_gate(bus.req_a[win], bus.req_b[win], bus.req_op[win]);
        m_id   = 2'(win);
        m_ptr  = (win + 1) % N;
        pend[win] = 1'b0;
      end else if (m_full && bus.rsp_ready) begin
        m_full = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_opcodes();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_gate_arbiter.md
RR_GATE_ARBITER -- requirements
Module: rr_gate_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter W, default 8: operand/result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester request valid.
REQ-006 req_ready  output  N_REQ  per-requester grant/accept; at most one bit high per cycle.
REQ-007 req_a  input  N_REQ x W  per-requester operand A.
REQ-008 req_b  input  N_REQ x W  per-requester operand B.
REQ-009 req_op  input  N_REQ x 2  per-requester gate opcode.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  downstream accepts result.
REQ-012 rsp_data  output  W  gate result.
REQ-013 rsp_id  output  clog2(N_REQ)  index of the requester that produced rsp_data.

Function
REQ-014 Opcodes, bitwise over W: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored).
REQ-015 All opcodes SHALL be evaluated by one shared gate unit built only from 2:1 mux instances and constants 0/1; no behavioural &, |, ^, ~ for the result.
REQ-016 Request transfer occurs on cycle where req_valid[i] && req_ready[i]; a requester SHALL hold valid, a, b and op stable until transfer.
REQ-017 req_ready[i] SHALL be high only if req_valid[i] is high, i is the round-robin winner, and the output stage can accept (EMPTY, or FULL with rsp_ready high).
REQ-018 Round-robin: search starts at pointer ptr, ascending with wrap N_REQ-1 -> 0; first valid index wins.
REQ-019 On transfer from index g, ptr SHALL become (g+1) mod N_REQ next cycle; no transfer leaves ptr unchanged.
REQ-020 Output stage FSM, states EMPTY, FULL: EMPTY + transfer -> FULL; FULL + rsp_ready + no transfer -> EMPTY; FULL + rsp_ready + transfer -> FULL with new data; FULL + !rsp_ready -> FULL, outputs held.
REQ-021 Latency: result of a transfer in cycle t SHALL appear on rsp_data/rsp_id with rsp_valid high in cycle t+1.
REQ-022 rsp_valid SHALL be high iff state FULL; rsp_data and rsp_id SHALL not change while rsp_valid && !rsp_ready.
REQ-023 Simultaneous drain and transfer SHALL sustain one result per cycle with no bubble.
REQ-024 No valid requests: req_ready all 0, ptr unchanged.
REQ-025 req_valid deasserted by a non-granted requester SHALL not affect the current grant.

Reset
REQ-026 With rst high at a clock edge: state EMPTY, ptr 0, rsp_valid 0, rsp_data 0, rsp_id 0.
REQ-027 While rst is high, req_ready SHALL be all 0; a pending result is discarded (reset mid-operation drops it, no transfer counted).
REQ-028 First grant after reset SHALL go to the lowest-index valid requester.

Structure
REQ-029 Shared package rr_gate_pkg SHALL hold the gate_op_t opcode enum (OP_AND, OP_OR, OP_XOR, OP_NOT_A) and default N_REQ/W constants.
REQ-030 One sub-module mux_gate_unit (a, b, op -> y, W-bit, purely combinational, mux instances only) SHALL implement REQ-014/015; arbiter, ptr and FSM stay in rr_gate_arbiter.

Verification
REQ-031 Single request: req 2 valid, a=8'hF0, b=8'h3C, op=XOR, rsp_ready=1 -> req_ready=4'b0100 one cycle, next cycle rsp_valid=1, rsp_data=8'hCC, rsp_id=2.
REQ-032 All 4 valid continuously, rsp_ready=1, after reset -> grants 0,1,2,3,0,... one per cycle, rsp_id follows one cycle later, no bubbles.
REQ-033 Backpressure: rsp_ready=0 with FULL holding id 1 -> rsp_data/rsp_id stable, req_ready=0; raise rsp_ready -> drain and new grant same cycle.
REQ-034 Opcode sweep, a=8'hA5, b=8'h0F: AND 8'h05, OR 8'hAF, XOR 8'hAA, NOT_A 8'h5A.
REQ-035 Wrap/skip: ptr=3, only req 1 valid -> grant 1, ptr becomes 2.
REQ-036 Reset mid-operation: rst high while FULL -> next cycle rsp_valid=0, ptr=0, rsp_data=0.
